// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet framing constants, transmit state encoding and CRC helper
package eth_pkg;
  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_t;
  function automatic logic [31:0] bitrev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: reflected CRC-32 next state after absorbing one byte, LSB first
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  localparam logic [31:0] POLY_R = bitrev32(CRC32_POLY);
  logic [31:0] c;
  always_comb begin
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ POLY_R : c >> 1;
    crc_out = c;
  end
endmodule

// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: wraps a payload stream in preamble, SFD, pad and FCS, then enforces the IFG
module gmii_tx_framer
  import eth_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned MIN_PAYLOAD  = 60,
  parameter int unsigned IFG_CYCLES   = 12
) (
  input  logic       gmii_tx_clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic [7:0] gmii_txd
);
  localparam logic [7:0]  PRE_N    = 8'(PREAMBLE_LEN);
  localparam logic [10:0] MIN_N    = 11'(MIN_PAYLOAD);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);
  tx_state_t   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, txd_q, txd_d;
  logic [10:0] bcnt_q, bcnt_d, bcnt_inc;
  logic [31:0] crc_q, crc_d, crc_nxt, fcs;
  logic        last_q, last_d, en_q, en_d, er_q, er_d, done_q, done_d, err_q, err_d;
  assign tx_ready = state_q == ST_SFD || (state_q == ST_DATA && !last_q);
  assign bcnt_inc = (&bcnt_q) ? bcnt_q : bcnt_q + 11'd1;
  assign fcs      = ~crc_q;
  // Pad bytes are zeros, so the CRC sees 0x00 whenever no payload beat is being taken
  crc32_d8 u_crc (
    .crc_in (crc_q),
    .data   (tx_ready ? tx_data : 8'h00),
    .crc_out(crc_nxt)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    crc_d   = crc_q;
    last_d  = last_q;
    txd_d   = 8'h00;
    en_d    = 1'b0;
    er_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (tx_valid) begin
        state_d = ST_PRE;
        cnt_d   = 8'd1;
        bcnt_d  = '0;
        crc_d   = CRC32_INIT;
        last_d  = 1'b0;
        txd_d   = ETH_PREAMBLE;
        en_d    = 1'b1;
      end
      ST_PRE: begin
        en_d    = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        txd_d   = (cnt_q == PRE_N) ? ETH_SFD : ETH_PREAMBLE;
        state_d = (cnt_q == PRE_N) ? ST_SFD : ST_PRE;
      end
      ST_SFD, ST_DATA, ST_PAD: begin
        en_d = 1'b1;
        if (state_q == ST_PAD || last_q) begin
          if (bcnt_q < MIN_N) begin
            state_d = ST_PAD;
            crc_d   = crc_nxt;
            bcnt_d  = bcnt_inc;
          end else begin
            state_d = ST_FCS;
            cnt_d   = '0;
            txd_d   = fcs[7:0];
          end
        end else if (tx_valid) begin
          state_d = ST_DATA;
          txd_d   = tx_data;
          crc_d   = crc_nxt;
          bcnt_d  = bcnt_inc;
          last_d  = tx_last;
        end else if (state_q == ST_SFD) begin
          txd_d = ETH_PREAMBLE;
        end else begin
          // Underrun: one errored symbol, then straight to the gap with no FCS
          state_d = ST_IFG;
          cnt_d   = '0;
          er_d    = 1'b1;
          err_d   = 1'b1;
        end
      end
      ST_FCS: begin
        if (cnt_q == 8'd3) begin
          state_d = (IFG_LAST == 8'd0) ? ST_IDLE : ST_IFG;
          cnt_d   = (IFG_LAST == 8'd0) ? 8'd0 : 8'd1;
        end else begin
          en_d   = 1'b1;
          cnt_d  = cnt_q + 8'd1;
          txd_d  = fcs[{cnt_d[1:0], 3'b000} +: 8];
          done_d = cnt_q == 8'd2;
        end
      end
      ST_IFG: begin
        state_d = (cnt_q >= IFG_LAST) ? ST_IDLE : ST_IFG;
        cnt_d   = (cnt_q >= IFG_LAST) ? 8'd0 : cnt_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge gmii_tx_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      crc_q   <= CRC32_INIT;
      last_q  <= 1'b0;
      txd_q   <= '0;
      en_q    <= 1'b0;
      er_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      crc_q   <= crc_d;
      last_q  <= last_d;
      txd_q   <= txd_d;
      en_q    <= en_d;
      er_q    <= er_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign gmii_txd   = txd_q;
  assign gmii_tx_en = en_q;
  assign gmii_tx_er = er_q;
  assign tx_done    = done_q;
  assign tx_err     = err_q;
endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb_gmii_tx_framer: scoreboard bench; dut 0 has padding disabled, dut 1 uses default parameters
module tb_gmii_tx_framer;
  typedef struct packed {
    logic       er;
    logic       done;
    logic       err;
    logic [7:0] txd;
  } exp_t;
  typedef logic [7:0] bq_t[$];
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v[2], l[2], r[2], done[2], err[2], en[2], er[2], gap_chk[2];
  logic [7:0] d[2], txd[2];
  exp_t       exp_q[2][$];
  int         checks = 0;
  int         passed = 0;
  always #4 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    gmii_tx_framer #(
      .PREAMBLE_LEN(7),
      .MIN_PAYLOAD (g == 0 ? 0 : 60),
      .IFG_CYCLES  (12)
    ) dut (
      .gmii_tx_clk(clk),
      .rst        (rst),
      .tx_valid   (v[g]),
      .tx_data    (d[g]),
      .tx_last    (l[g]),
      .tx_ready   (r[g]),
      .tx_done    (done[g]),
      .tx_err     (err[g]),
      .gmii_tx_en (en[g]),
      .gmii_tx_er (er[g]),
      .gmii_txd   (txd[g])
    );
  end
  task automatic chk(string name, int g, logic [15:0] act, logic [15:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s dut%0d actual=%h required=%h t=%0t", name, g, act, req, $time);
  endtask
  // Monitor: pops one expected symbol per enabled cycle and checks idle/reset/gap behaviour
  initial begin
    exp_t e;
    int   gap[2];
    logic pen[2];
    gap = '{0, 0};
    pen = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (rst) begin
          chk("reset", g, {3'b0, en[g], er[g], r[g], done[g], err[g], txd[g]}, 16'h0);
          gap[g] = 0;
          pen[g] = 1'b0;
        end else if (en[g]) begin
          if (!pen[g] && gap_chk[g]) chk("ifg_gap", g, 16'(gap[g]), 16'd12);
          if (exp_q[g].size() == 0) begin
            checks++;
            $display("FAIL unexpected dut%0d actual=%h required=none t=%0t", g, {er[g], done[g], err[g], txd[g]}, $time);
          end else begin
            e = exp_q[g].pop_front();
            chk("byte", g, {5'b0, er[g], done[g], err[g], txd[g]}, {5'b0, e});
          end
          gap[g] = 0;
          pen[g] = 1'b1;
        end else begin
          chk("idle", g, {5'b0, er[g], done[g], err[g], txd[g]}, 16'h0);
          gap[g]++;
          pen[g] = 1'b0;
        end
      end
    end
  end
  function automatic exp_t mk(logic e_r, logic dn, logic e_rr, logic [7:0] b);
    return {e_r, dn, e_rr, b};
  endfunction
  function automatic logic [31:0] crc_model(bq_t b);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
      end
    end
    return ~c;
  endfunction
  function automatic bq_t ramp(int n, logic [7:0] s);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(s + 8'(i * 3));
    return q;
  endfunction
  function automatic void push_frame(int g, bq_t p, int stall, int abort_at, bit use_fcs, logic [31:0] fcs_in);
    bq_t         body;
    logic [31:0] fcs;
    int          minp;
    minp = (g == 0) ? 0 : 60;
    repeat (7) exp_q[g].push_back(mk(0, 0, 0, 8'h55));
    exp_q[g].push_back(mk(0, 0, 0, 8'hD5));
    repeat (stall) exp_q[g].push_back(mk(0, 0, 0, 8'h55));
    foreach (p[i]) begin
      if (i == abort_at) begin
        exp_q[g].push_back(mk(1, 0, 1, 8'h00));
        return;
      end
      exp_q[g].push_back(mk(0, 0, 0, p[i]));
      body.push_back(p[i]);
    end
    while (body.size() < minp) begin
      body.push_back(8'h00);
      exp_q[g].push_back(mk(0, 0, 0, 8'h00));
    end
    fcs = use_fcs ? fcs_in : crc_model(body);
    for (int k = 0; k < 4; k++) exp_q[g].push_back(mk(0, k == 3, 0, fcs[8*k +: 8]));
  endfunction
  task automatic wait_ready(int g);
    int n;
    n = 0;
    while (!r[g]) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        $display("FAIL ready_timeout dut%0d actual=0 required=1", g);
        $fatal(1, "tx_ready never rose");
      end
    end
  endtask
  task automatic send(int g, bq_t p, int stall, int abort_at, int rst_at);
    for (int i = 0; i < p.size(); i++) begin
      if (i == abort_at) begin
        v[g] = 1'b0;
        l[g] = 1'b0;
        @(negedge clk);
        return;
      end
      if (i == rst_at) begin
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q[0].delete();
        exp_q[1].delete();
        @(posedge clk);
        #1 rst = 1'b0;
        v[g] = 1'b0;
        l[g] = 1'b0;
        @(negedge clk);
        return;
      end
      v[g] = 1'b1;
      d[g] = p[i];
      l[g] = (i == p.size() - 1);
      if (i == 0 && stall > 0) begin
        @(negedge clk);
        v[g] = 1'b0;
        wait_ready(g);
        repeat (stall) @(negedge clk);
        v[g] = 1'b1;
      end
      wait_ready(g);
      @(negedge clk);
    end
    v[g] = 1'b0;
    l[g] = 1'b0;
  endtask
  initial begin
    bq_t p;
    int  n;
    v       = '{1'b0, 1'b0};
    l       = '{1'b0, 1'b0};
    d       = '{8'h00, 8'h00};
    gap_chk = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    push_frame(0, p, 0, -1, 1, 32'hCBF43926);
    send(0, p, 0, -1, -1);
    repeat (30) @(negedge clk);
    p = '{8'h5A};
    push_frame(0, p, 0, -1, 0, 0);
    send(0, p, 0, -1, -1);
    repeat (30) @(negedge clk);
    p = '{8'hAB};
    push_frame(1, p, 0, -1, 0, 0);
    send(1, p, 0, -1, -1);
    repeat (30) @(negedge clk);
    p = ramp(64, 8'h00);
    push_frame(1, p, 0, -1, 0, 0);
    send(1, p, 0, -1, -1);
    gap_chk[1] = 1'b1;
    p = ramp(64, 8'h80);
    push_frame(1, p, 0, -1, 0, 0);
    send(1, p, 0, -1, -1);
    gap_chk[1] = 1'b0;
    repeat (30) @(negedge clk);
    p = ramp(20, 8'h10);
    push_frame(1, p, 0, 10, 0, 0);
    send(1, p, 0, 10, -1);
    gap_chk[1] = 1'b1;
    p = ramp(5, 8'hC0);
    push_frame(1, p, 0, -1, 0, 0);
    send(1, p, 0, -1, -1);
    gap_chk[1] = 1'b0;
    repeat (90) @(negedge clk);
    p = ramp(20, 8'h40);
    push_frame(1, p, 0, -1, 0, 0);
    send(1, p, 0, -1, 5);
    repeat (5) @(negedge clk);
    p = ramp(8, 8'h21);
    push_frame(1, p, 0, -1, 0, 0);
    send(1, p, 0, -1, -1);
    repeat (90) @(negedge clk);
    p = ramp(10, 8'h99);
    push_frame(1, p, 3, -1, 0, 0);
    send(1, p, 3, -1, -1);
    n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
      $display("FAIL drain actual=%0d/%0d required=0/0 pending", exp_q[0].size(), exp_q[1].size());
      $fatal(1, "expected symbols never appeared");
    end
    repeat (20) @(negedge clk);
    #1 $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/gmii_tx_framer.md
Name: gmii_tx_framer

Overview:
Transmit-side Ethernet framer; the counterpart of the RGMII/GMII receive path.
- Accepts a payload byte stream over a valid/ready handshake and emits a complete GMII frame: 7-byte preamble, SFD, payload, zero pad to the minimum length, CRC-32 FCS, then an enforced inter-frame gap.
- Sits between the packet builder (gmii_tx_clk domain) and the RGMII transmit DDR stage (ODDR-based rgmii_tx).

Parameters:
- PREAMBLE_LEN, 7: number of 0x55 bytes before the SFD (range 1-15).
- MIN_PAYLOAD, 60: minimum payload+pad bytes before the FCS; 0 disables padding.
- IFG_CYCLES, 12: idle cycles after the last FCS byte (range 1-255).

Ports:
- gmii_tx_clk  in  1  125 MHz GMII transmit clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- tx_valid  in  1  payload byte valid.
- tx_data  in  8  payload byte.
- tx_last  in  1  marks the final payload byte; qualified by tx_valid.
- tx_ready  out  1  payload byte accepted when tx_valid & tx_ready.
- tx_done  out  1  one-cycle pulse on the cycle the last FCS byte is driven.
- tx_err  out  1  one-cycle pulse on underrun abort.
- gmii_tx_en  out  1  GMII transmit enable.
- gmii_tx_er  out  1  GMII transmit error.
- gmii_txd  out  8  GMII transmit data.

Behaviour:
- Reset (async assert, synchronous release by clock edge): state IDLE; gmii_tx_en=0, gmii_tx_er=0, gmii_txd=0x00; tx_ready=0, tx_done=0, tx_err=0; CRC=0xFFFFFFFF; all counters 0. Reset mid-frame aborts immediately with no FCS.
- gmii_txd, gmii_tx_en, gmii_tx_er, tx_done and tx_err are registered and update with the state. tx_ready is combinational from state and registered flags only; it never depends on tx_valid.
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG.
- IDLE: when tx_valid=1 in cycle 0, go to PRE. gmii_txd=0x55 and gmii_tx_en=1 in cycles 1..PREAMBLE_LEN.
- SFD: 0xD5 is driven in cycle PREAMBLE_LEN+1.
- tx_ready=1 during SFD and DATA, until the tx_last beat is accepted. Each accepted byte is driven on gmii_txd in the following cycle, so byte 0 appears in cycle PREAMBLE_LEN+2.
- Payload byte counter: 11-bit, saturating at 2047.
- After the tx_last beat is accepted: if count < MIN_PAYLOAD, go to PAD and drive 0x00 until count == MIN_PAYLOAD; otherwise go to FCS.
- CRC-32: polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF, over payload plus pad, one byte per cycle.
- FCS: the ones-complement of the CRC is driven LSB byte first over 4 cycles. tx_done pulses with the 4th FCS byte.
- IFG: gmii_tx_en=0, gmii_txd=0x00 for IFG_CYCLES cycles, then IDLE. tx_valid is ignored in IFG; a pending tx_valid starts a new frame on the first IDLE cycle.
- Underrun: tx_ready=1 in DATA (after byte 0) and tx_valid=0 aborts the frame.
  - Next cycle: gmii_tx_en=1, gmii_tx_er=1, gmii_txd=0x00, tx_err pulses.
  - Then go to IFG with no FCS.
  - Abort is never triggered in SFD: there, tx_valid=0 simply stalls by repeating a 0x55 byte. Implementation drives the extra preamble byte while waiting.
- A tx_last beat that is byte 0 is legal; that frame is padded.

Decomposition:
- Shared package eth_pkg:
  - constants ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, CRC32_POLY, CRC32_INIT, CRC32_RESIDUE=32'hC704DD7B;
  - state enum tx_state_t.
- Sub-module crc32_d8: combinational next-CRC for one data byte. Inputs: crc_in[31:0], data[7:0]. Output: crc_out[31:0]. The register is kept in the framer.

Test Plan:
- MIN_PAYLOAD=0, payload "123456789" (0x31..0x39), continuous valid -> on gmii_txd: 7×0x55, 0xD5, 9 bytes, then FCS 0x26,0x39,0xF4,0xCB; gmii_tx_en high for exactly 21 cycles; tx_done on the 21st.
- Default params, 1-byte payload 0xAB -> 0xAB followed by 59×0x00 pad, then 4 FCS bytes matching the reference model; frame is 72 enable cycles.
- Two back-to-back 64-byte frames with tx_valid held high -> exactly 12 gmii_tx_en=0 cycles between frames; second preamble starts on the 13th cycle after tx_done.
- Drop tx_valid for 1 cycle at payload byte 10 -> gmii_tx_er=1 for 1 cycle, tx_err pulse, no FCS, IFG observed, next frame clean.
- Assert rst during payload byte 5 -> gmii_tx_en/gmii_tx_er/tx_ready are 0 before the next clock edge; the next frame after release is correct from its preamble.
- Hold tx_valid=0 during SFD entry -> extra 0x55 bytes, no tx_err; FCS of the subsequent payload is still correct.
